// File: rtl/div_unit_if.sv
// div_unit_if: request/result handshake bundle for the iterative divider.
//   master: issue side, drives requests and accepts results.
//   slave : the divider.
//   in_valid/in_ready/div_sel/op1/op2 : request channel.
//   out_valid/out_ready/res           : result channel.
interface div_unit_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    div_sel;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] res;

    modport master (
        output in_valid, div_sel, op1, op2, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, div_sel, op1, op2, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   flush : synchronous kill of any op in flight.
//   bus   : div_unit_if slave (request in, result out).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, accepts a request on in_valid
// CALC  | one quotient bit per cycle; last cycle applies sign fixup
// DONE  | out_valid=1, res held until out_ready
module div_unit #(
    parameter int DW = 32
) (
    input logic       clk,
    input logic       rst_n,
    input logic       flush,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] res_q, res_d;
    logic [1:0]    sel_q, sel_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    // fin: iterations are finished, next CALC edge moves to DONE.
    // fixed: res already holds a fast-path result, skip the fixup.
    logic          fin_q, fin_d;
    logic          fixed_q, fixed_d;

    logic [DW:0]   trial;
    logic [DW:0]   diff;
    logic          ge;
    logic          sgn_op;
    logic          a_neg;
    logic          b_neg;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        sel_d   = sel_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        fin_d   = fin_q;
        fixed_d = fixed_q;

        // The partial remainder is always below the divisor, so the
        // DW+1-bit difference is negative exactly when trial < divisor.
        trial = {rem_q, quo_q[DW-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = ~diff[DW];

        sgn_op = ~bus.div_sel[0];
        a_neg  = sgn_op & bus.op1[DW-1];
        b_neg  = sgn_op & bus.op2[DW-1];

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_CALC;
                    sel_d   = bus.div_sel;
                    s1_d    = a_neg;
                    s2_d    = b_neg;
                    quo_d   = a_neg ? -bus.op1 : bus.op1;
                    dvs_d   = b_neg ? -bus.op2 : bus.op2;
                    rem_d   = '0;
                    cnt_d   = CW'(DW - 1);
                    fin_d   = 1'b0;
                    fixed_d = 1'b0;
                    if (bus.op2 == '0) begin
                        fin_d   = 1'b1;
                        fixed_d = 1'b1;
                        res_d   = bus.div_sel[1] ? bus.op1 : '1;
                    end else if (sgn_op && bus.op1 == {1'b1, {(DW-1){1'b0}}}
                                 && bus.op2 == '1) begin
                        fin_d   = 1'b1;
                        fixed_d = 1'b1;
                        res_d   = bus.div_sel[1] ? '0 : bus.op1;
                    end
                end
            end
            S_CALC: begin
                if (fin_q) begin
                    state_d = S_DONE;
                    if (!fixed_q) begin
                        if (sel_q[1])
                            res_d = s1_q ? -rem_q : rem_q;
                        else
                            res_d = (s1_q ^ s2_q) ? -quo_q : quo_q;
                    end
                end else begin
                    rem_d = ge ? diff[DW-1:0] : trial[DW-1:0];
                    quo_d = {quo_q[DW-2:0], ge};
                    if (cnt_q == '0)
                        fin_d = 1'b1;
                    else
                        cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            fin_d   = 1'b0;
            fixed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            sel_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            fin_q   <= 1'b0;
            fixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            fin_q   <= fin_d;
            fixed_q <= fixed_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.res       = res_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    div_unit_if #(.DW(DW)) bus ();

    div_unit #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M rules.
    function automatic logic [DW-1:0] model_res(input logic [1:0] sel,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic signed [DW-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return sel[1] ? a : {DW{1'b1}};
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return sel[1] ? '0 : a;
        case (sel)
            2'd0: return sa / sb;
            2'd1: return a / b;
            2'd2: return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] sel,
                                     input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        if (b == 0) return 1;
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DW + 1;
    endfunction

    // Transaction-level model: busy flag, edge at which the result is due,
    // and the expected result. Driven only from bench inputs.
    int            cyc = 0;
    bit            m_busy = 0;
    int            m_due = 0;
    logic [DW-1:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
        end else begin
            cyc = cyc + 1;
            if (flush) begin
                m_busy = 0;
            end else if (!m_busy && bus.in_valid) begin
                m_busy = 1;
                m_due  = cyc + model_lat(bus.div_sel, bus.op1, bus.op2);
                m_res  = model_res(bus.div_sel, bus.op1, bus.op2);
            end else if (m_busy && cyc > m_due && bus.out_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("rst_res", bus.res, '0);
        end else begin
            chk("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, !m_busy});
            chk("cyc_out_valid", {31'b0, bus.out_valid}, {31'b0, (m_busy && cyc >= m_due)});
            if (m_busy && cyc >= m_due)
                chk("cyc_res", bus.res, m_res);
        end
    end

    task automatic run_op(input string nm, input logic [1:0] sel,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_res, input int exp_lat,
                          input int hold);
        int acc;
        int n;
        @(negedge clk);
        chk({nm, "_idle"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.div_sel   = sel;
        bus.op1       = a;
        bus.op2       = b;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        acc = cyc;
        bus.in_valid = 1'b0;
        bus.op1      = $urandom;
        bus.op2      = $urandom;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, cyc - acc, exp_lat);
        chk({nm, "_res"}, bus.res, exp_res);
        for (int i = 0; i < hold; i++) begin
            chk({nm, "_hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
            chk({nm, "_hold_res"}, bus.res, exp_res);
            chk({nm, "_hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_release"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.div_sel   = 2'd0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, DW + 1, 0);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, DW + 1, 0);
        run_op("div_m20_3", 2'd0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DW + 1, 0);
        run_op("rem_m20_3", 2'd2, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DW + 1, 0);
        run_op("rem_20_m3", 2'd2, 32'd20, 32'hFFFF_FFFD, 32'd2, DW + 1, 0);
        run_op("div_m20_m3", 2'd0, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, DW + 1, 0);
        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DW + 1, 0);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DW + 1, 0);
        run_op("remu_max_16", 2'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, DW + 1, 0);
        run_op("divu_5_10", 2'd1, 32'd5, 32'd10, 32'd0, DW + 1, 0);
        run_op("div_min_2", 2'd0, 32'h8000_0000, 32'd2, 32'hC000_0000, DW + 1, 0);
        run_op("divu_by0", 2'd1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_by0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("divu_bp", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, DW + 1, 10);

        // flush part-way through CALC
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.div_sel  = 2'd1;
        bus.op1      = 32'd1000;
        bus.op2      = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("flush_no_result", {31'b0, bus.out_valid}, 32'd0);
        run_op("divu_9_2", 2'd1, 32'd9, 32'd2, 32'd4, DW + 1, 0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.div_sel  = 2'd0;
        bus.op1      = 32'd77;
        bus.op2      = 32'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("arst_res", bus.res, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_result", {31'b0, bus.out_valid}, 32'd0);
        run_op("divu_after_rst", 2'd1, 32'd100, 32'd7, 32'd14, DW + 1, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
